pipe_stage_buf: RTL and testbench

//  Parametrised pipeline-stage register with a valid/ready handshake, stall, flush and an optional skid entry.

---
 rtl/pipe_stage_buf.sv | 121 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, stall hold, flush-to-bubble,
// optional skid entry and sticky detection of upstream handshake violations.
module pipe_stage_buf #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_err,
  output logic              proto_err,
  output logic [1:0]        count
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              err;
  } entryT;

  entryT inEntry;
  entryT headQ, skidQ, headNext, skidNext, heldQ;
  logic  headValid, skidValid, headValidNext, skidValidNext;
  logic  accept, emit;
  logic  pendQ, protoErrQ, violation;

  assign inEntry = {in_ctrl, in_data, in_sel, in_err};
  assign accept  = in_valid & in_ready;
  assign emit    = headValid & out_ready;

  // Emit first (skid shifts into head), then the accepted word fills the
  // first free slot, which keeps FIFO order without separate case arms.
  always_comb begin
    headNext      = headQ;
    skidNext      = skidQ;
    headValidNext = headValid;
    skidValidNext = skidValid;
    if (flush) begin
      headValidNext = 1'b0;
      skidValidNext = 1'b0;
    end else begin
      if (emit) begin
        headValidNext = skidValid;
        skidValidNext = 1'b0;
        if (skidValid) headNext = skidQ;
      end
      if (accept) begin
        if (!headValidNext) begin
          headNext      = inEntry;
          headValidNext = 1'b1;
        end else if (SKID != 0) begin
          skidNext      = inEntry;
          skidValidNext = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headQ     <= '0;
      skidQ     <= '0;
      headValid <= 1'b0;
      skidValid <= 1'b0;
    end else begin
      headQ     <= headNext;
      skidQ     <= skidNext;
      headValid <= headValidNext;
      skidValid <= skidValidNext;
    end
  end

  if (SKID != 0) begin : gSkid
    logic readyQ;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) readyQ <= 1'b1;
      else      readyQ <= ~(headValidNext & skidValidNext);
    end
    assign in_ready = rst & readyQ;
  end else begin : gSingle
    assign in_ready = rst & (~headValid | out_ready);
  end

  // A word offered but refused last cycle must be re-offered unchanged.
  assign violation = pendQ & (~in_valid | (inEntry != heldQ));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendQ     <= 1'b0;
      heldQ     <= '0;
      protoErrQ <= 1'b0;
    end else begin
      pendQ     <= in_valid & ~in_ready & ~flush;
      heldQ     <= inEntry;
      protoErrQ <= protoErrQ | violation;
    end
  end

  assign out_valid = headValid;
  assign out_ctrl  = headValid ? headQ.ctrl : '0;
  assign out_data  = headQ.data;
  assign out_sel   = headValid ? headQ.sel : '0;
  assign out_err   = headQ.err & headValid;
  assign proto_err = protoErrQ;
  assign count     = 2'(headValid) + 2'(skidValid);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=0 and SKID=1 instances, queue reference model
// with a negedge monitor, directed scenarios plus a randomized handshake phase.
module tb_pipe_stage_buf;

  localparam int CW = 16;
  localparam int DW = 64;
  localparam int SW = 3;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic          err;
  } entT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush[2], inValid[2], inReady[2], inErr[2];
  logic          outValid[2], outReady[2], outErr[2], protoErr[2];
  logic [CW-1:0] inCtrl[2], outCtrl[2];
  logic [DW-1:0] inData[2], outData[2];
  logic [SW-1:0] inSel[2], outSel[2];
  logic [1:0]    count[2];

  int unsigned nChecks = 0;
  int unsigned nPass   = 0;

  task automatic chk(string name, int unsigned idx, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s (skid=%0d): got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SEL_W(SW), .SKID(g)) dut (
      .clk(clk), .rst(rst), .flush(flush[g]),
      .in_valid(inValid[g]), .in_ready(inReady[g]),
      .in_ctrl(inCtrl[g]), .in_data(inData[g]), .in_sel(inSel[g]), .in_err(inErr[g]),
      .out_valid(outValid[g]), .out_ready(outReady[g]),
      .out_ctrl(outCtrl[g]), .out_data(outData[g]), .out_sel(outSel[g]), .out_err(outErr[g]),
      .proto_err(protoErr[g]), .count(count[g])
    );

    entT  q[$];
    logic pend     = 1'b0;
    logic expProto = 1'b0;
    entT  held     = '0;

    always @(negedge rst) begin
      q.delete();
      pend     = 1'b0;
      expProto = 1'b0;
    end

    // Predictor: accepted words are pushed, emitted words popped, flush empties.
    always @(posedge clk) begin
      if (rst) begin
        logic rdy;
        entT  cur;
        rdy = (g == 1) ? (q.size() < 2) : (q.size() == 0 || outReady[g]);
        cur = {inCtrl[g], inData[g], inSel[g], inErr[g]};
        if (pend && (!inValid[g] || cur != held)) expProto = 1'b1;
        pend = inValid[g] && !rdy && !flush[g];
        held = cur;
        if (flush[g]) q.delete();
        else begin
          if (q.size() != 0 && outReady[g]) void'(q.pop_front());
          if (inValid[g] && rdy) q.push_back(cur);
        end
      end
    end

    always @(negedge clk) begin
      int unsigned n;
      logic        rdy;
      n = q.size();
      if (!rst) begin
        chk("rst_out_valid", g, 64'(outValid[g]), 64'(0));
        chk("rst_count", g, 64'(count[g]), 64'(0));
        chk("rst_in_ready", g, 64'(inReady[g]), 64'(0));
        chk("rst_out_ctrl", g, 64'(outCtrl[g]), 64'(0));
        chk("rst_out_sel", g, 64'(outSel[g]), 64'(0));
        chk("rst_out_err", g, 64'(outErr[g]), 64'(0));
        chk("rst_proto_err", g, 64'(protoErr[g]), 64'(0));
      end else begin
        rdy = (g == 1) ? (n < 2) : (n == 0 || outReady[g]);
        chk("out_valid", g, 64'(outValid[g]), 64'(n != 0));
        chk("count", g, 64'(count[g]), 64'(n));
        chk("in_ready", g, 64'(inReady[g]), 64'(rdy));
        chk("proto_err", g, 64'(protoErr[g]), 64'(expProto));
        if (n != 0) begin
          chk("out_ctrl", g, 64'(outCtrl[g]), 64'(q[0].ctrl));
          chk("out_data", g, outData[g], q[0].data);
          chk("out_sel", g, 64'(outSel[g]), 64'(q[0].sel));
          chk("out_err", g, 64'(outErr[g]), 64'(q[0].err));
        end else begin
          chk("bubble_ctrl", g, 64'(outCtrl[g]), 64'(0));
          chk("bubble_err", g, 64'(outErr[g]), 64'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(int i, logic v, logic [CW-1:0] c, logic [DW-1:0] d, logic [SW-1:0] s, logic e);
    inValid[i] = v;
    inCtrl[i]  = c;
    inData[i]  = d;
    inSel[i]   = s;
    inErr[i]   = e;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0;
      outReady[i] = 1'b1;
      setIn(i, 1'b0, '0, '0, '0, 1'b0);
    end
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("first_in_ready", 0, 64'(inReady[0]), 64'(1));
    chk("first_in_ready", 1, 64'(inReady[1]), 64'(1));

    // Streaming with no back-pressure: one-cycle latency, in order.
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < 2; i++) setIn(i, 1'b1, 16'(k), {$urandom, $urandom}, 3'(k), 1'b0);
      tick();
      chk("t1_ctrl", 0, 64'(outCtrl[0]), 64'(k));
      chk("t1_ctrl", 1, 64'(outCtrl[1]), 64'(k));
      chk("t1_count_le1", 1, 64'(count[1] <= 2'd1), 64'(1));
    end
    for (int i = 0; i < 2; i++) inValid[i] = 1'b0;
    tick();
    chk("t1_drained", 1, 64'(outValid[1]), 64'(0));

    // Skid fill under stall, then release.
    outReady[1] = 1'b0;
    setIn(1, 1'b1, 16'h0001, 64'hA1, 3'd1, 1'b0); tick();
    setIn(1, 1'b1, 16'h0002, 64'hA2, 3'd2, 1'b0); tick();
    setIn(1, 1'b1, 16'h0003, 64'hA3, 3'd3, 1'b0);
    #1;
    chk("t2_count", 1, 64'(count[1]), 64'(2));
    chk("t2_in_ready", 1, 64'(inReady[1]), 64'(0));
    chk("t2_head", 1, 64'(outCtrl[1]), 64'h0001);
    tick(); tick();
    outReady[1] = 1'b1;
    tick();
    chk("t2_second", 1, 64'(outCtrl[1]), 64'h0002);
    tick();
    chk("t2_third", 1, 64'(outCtrl[1]), 64'h0003);
    inValid[1] = 1'b0;
    tick();
    chk("t2_empty", 1, 64'(outValid[1]), 64'(0));

    // Flush with two held entries and a word on the input.
    outReady[1] = 1'b0;
    setIn(1, 1'b1, 16'h0011, 64'hB1, 3'd1, 1'b0); tick();
    setIn(1, 1'b1, 16'h0012, 64'hB2, 3'd2, 1'b0); tick();
    setIn(1, 1'b1, 16'h0013, 64'hB3, 3'd3, 1'b0);
    flush[1] = 1'b1;
    #1 chk("t3_pre_count", 1, 64'(count[1]), 64'(2));
    tick();
    flush[1] = 1'b0;
    inValid[1] = 1'b0;
    chk("t3_out_valid", 1, 64'(outValid[1]), 64'(0));
    chk("t3_out_ctrl", 1, 64'(outCtrl[1]), 64'(0));
    chk("t3_count", 1, 64'(count[1]), 64'(0));
    outReady[1] = 1'b1;
    tick(); tick();
    chk("t3_no_ghost", 1, 64'(outValid[1]), 64'(0));

    // err bit held through a stall, squashed by flush.
    outReady[1] = 1'b0;
    setIn(1, 1'b1, 16'h0021, 64'hE, 3'd5, 1'b1); tick();
    inValid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t4_err_held", 1, 64'(outErr[1]), 64'(1));
      tick();
    end
    flush[1] = 1'b1; tick(); flush[1] = 1'b0;
    chk("t4_err_flushed", 1, 64'(outErr[1]), 64'(0));
    outReady[1] = 1'b1;

    // Randomized traffic respecting the handshake.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acc[2];
      @(negedge clk);
      for (int i = 0; i < 2; i++) acc[i] = inValid[i] && inReady[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!inValid[i] || acc[i] || flush[i])
          setIn(i, $urandom_range(0, 3) != 0, 16'($urandom), {$urandom, $urandom},
                3'($urandom), $urandom_range(0, 7) == 0);
        outReady[i] = ((cyc / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        flush[i]    = $urandom_range(0, 39) == 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      inValid[i] = 1'b0;
      flush[i] = 1'b0;
      outReady[i] = 1'b1;
    end
    tick(); tick(); tick();

    // Payload changed while refused: sticky protocol error.
    outReady[1] = 1'b0;
    setIn(1, 1'b1, 16'h0031, 64'hC1, 3'd1, 1'b0); tick();
    setIn(1, 1'b1, 16'h0032, 64'hC2, 3'd2, 1'b0); tick();
    setIn(1, 1'b1, 16'h0033, 64'h1234, 3'd0, 1'b0);
    #1;
    chk("t5_in_ready", 1, 64'(inReady[1]), 64'(0));
    chk("t5_proto_before", 1, 64'(protoErr[1]), 64'(0));
    tick();
    chk("t5_proto_held", 1, 64'(protoErr[1]), 64'(0));
    inData[1] = 64'h5678;
    tick();
    chk("t5_proto_set", 1, 64'(protoErr[1]), 64'(1));
    inValid[1] = 1'b0;
    tick(); tick();
    chk("t5_proto_sticky", 1, 64'(protoErr[1]), 64'(1));
    flush[1] = 1'b1; tick(); flush[1] = 1'b0;
    chk("t5_proto_after_flush", 1, 64'(protoErr[1]), 64'(1));

    // Async reset with a full stage, then a fresh push.
    setIn(1, 1'b1, 16'h0051, 64'hD1, 3'd1, 1'b0); tick();
    setIn(1, 1'b1, 16'h0052, 64'hD2, 3'd2, 1'b0); tick();
    inValid[1] = 1'b0;
    chk("t6_full", 1, 64'(count[1]), 64'(2));
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_async_valid", 1, 64'(outValid[1]), 64'(0));
    chk("t6_async_count", 1, 64'(count[1]), 64'(0));
    chk("t6_async_ready", 1, 64'(inReady[1]), 64'(0));
    chk("t6_async_proto", 1, 64'(protoErr[1]), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    outReady[1] = 1'b1;
    setIn(1, 1'b1, 16'h0061, 64'hF1, 3'd6, 1'b0);
    #1 chk("t6_ready_rise", 1, 64'(inReady[1]), 64'(1));
    tick();
    chk("t6_first_valid", 1, 64'(outValid[1]), 64'(1));
    chk("t6_first_ctrl", 1, 64'(outCtrl[1]), 64'h0061);
    inValid[1] = 1'b0;
    tick();
    chk("t6_drained", 1, 64'(outValid[1]), 64'(0));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
